motor_cmd_exec: RTL
===================

MOTOR_CMD_EXEC -- requirements
Module: motor_cmd_exec

Interface
REQ-001 Parameter PWM_BITS, default 8: width of the PWM counter and duty register.
REQ-002 Parameter DWELL_CYCLES, default 1000: clocks with both motors off before a direction reversal.
REQ-003 Parameter RAMP_STEP_CYCLES, default 16: clocks per +1 duty increment during soft-start.
REQ-004 clk  in  1: single system clock; all state SHALL change on the rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 cmd  in  2: steering command: 2'b11 proceed, 2'b10 turn left (right motor only), 2'b01 turn right (left motor only), 2'b00 stop.
REQ-007 cmd_fwd  in  1: 1 = forward, 0 = reverse.
REQ-008 mot_l_pwm, mot_r_pwm  out  1 each: motor PWM drive.
REQ-009 mot_l_dir, mot_r_dir  out  1 each: motor direction; 1 = forward.
REQ-010 duty_o  out  PWM_BITS: current applied duty, for LED display.
REQ-011 state_o  out  2: FSM state encoding: STOP=0, RUN=1, DWELL=2.

Function
REQ-012 cmd and cmd_fwd SHALL be registered once; FSM, duty and direction registers SHALL act on the registered copies, so an input change is reflected at the outputs after 2 rising edges.
REQ-013 STOP: both PWMs 0; duty 0. On registered cmd != 00, go to RUN and load dir = cmd_fwd.
REQ-014 RUN: per-motor enable = the corresponding cmd bit (left = cmd[0], right = cmd[1]); both dir outputs = the latched dir.
REQ-015 RUN with cmd == 00: go to STOP; duty clears to 0 on that same edge.
REQ-016 RUN with cmd_fwd != latched dir: go to DWELL; PWMs forced to 0; duty cleared; dwell counter loaded to 0.
REQ-017 DWELL:
- Count to DWELL_CYCLES-1, then load dir = cmd_fwd and go to RUN with duty 0.
- If cmd_fwd toggles again during DWELL, the counter SHALL restart.
- If cmd == 00, go to STOP immediately.
REQ-018 A change among the nonzero cmd values in RUN with unchanged direction SHALL only change the motor enables; duty is unaffected.
REQ-019 PWM: free-running PWM_BITS counter wrapping 2^PWM_BITS-1 -> 0; mot_x_pwm = enable_x AND (cnt < duty).
- Duty 0 gives constant 0.
- Maximum duty (2^PWM_BITS-1) gives high for 255 of 256 counts.
REQ-020 Duty SHALL saturate at 2^PWM_BITS-1 and never wrap.

Reset
REQ-021 rst SHALL force, on the next edge:
- state STOP, duty 0, PWM counter 0, dwell and ramp counters 0;
- all PWMs 0, both dir 1, registered cmd 00;
- this applies regardless of current state, including mid-DWELL.

Configuration
REQ-022 With MOTOR_RAMP_EN defined: in RUN, duty SHALL increment by 1 every RAMP_STEP_CYCLES clocks from 0 up to saturation.
REQ-023 Without MOTOR_RAMP_EN: on entry to RUN, duty SHALL load 2^PWM_BITS-1 immediately; no ramp counter is instantiated.

Structure
REQ-024 Shared package motor_pkg SHALL hold the cmd encoding constants (CMD_STOP, CMD_RIGHT, CMD_LEFT, CMD_PROCEED) and the state type.
REQ-025 Sub-module pwm_gen (counter + compare, parameterised by PWM_BITS) SHALL be instantiated once; both motor outputs share its counter.

Verification (PWM_BITS=8, DWELL_CYCLES=20, RAMP_STEP_CYCLES=4)
REQ-026 Reset, then cmd=11, cmd_fwd=1:
- state_o=1 after 2 edges;
- with ramp: duty_o=1 after 4 more clocks, reaches 255 after 1020 clocks and holds;
- without ramp: duty_o=255 on RUN entry.
REQ-027 In RUN at duty 255, cmd=10 -> mot_l_pwm stays 0, mot_r_pwm toggles, duty unchanged; cmd=01 -> the mirror case.
REQ-028 In RUN fwd, cmd_fwd=0:
- state_o=2 and both PWMs 0 for 20 clocks;
- then dir outputs = 0, state_o=1, duty restarts at 0.
REQ-029 During DWELL:
- toggle cmd_fwd at count 10 -> dwell lasts a further 20 clocks;
- cmd=00 -> state_o=0 next edge.
REQ-030 Assert rst for 1 cycle mid-ramp (duty 100) -> next edge: duty_o=0, state_o=0, PWMs 0, dirs 1.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared encodings for the motor command executor: steering command codes
// and the controller state type.
package motor_pkg;

    localparam logic [1:0] CMD_STOP    = 2'b00;
    localparam logic [1:0] CMD_RIGHT   = 2'b01;
    localparam logic [1:0] CMD_LEFT    = 2'b10;
    localparam logic [1:0] CMD_PROCEED = 2'b11;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with one duty compare shared by both motor
// channels; each channel is gated by its own enable.
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                en_l,
    input  logic                en_r,
    output logic                pwm_l,
    output logic                pwm_r
);

    logic [PWM_BITS-1:0] cnt;
    logic                active;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_BITS'(1);
        end
    end

    // Strict compare: duty 0 never fires, full-scale duty misses only the top count.
    assign active = (cnt < duty);
    assign pwm_l  = en_l & active;
    assign pwm_r  = en_r & active;

endmodule

// File: rtl/motor_cmd_exec.sv
// Two-motor command executor: registers the steering command, sequences
// STOP/RUN/DWELL with a dead-time before reversals, and drives shared PWM.
// Optional soft-start ramp is enabled by defining MOTOR_RAMP_EN.
module motor_cmd_exec
    import motor_pkg::*;
#(
    parameter int PWM_BITS         = 8,
    parameter int DWELL_CYCLES     = 1000,
    parameter int RAMP_STEP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cmd,
    input  logic                cmd_fwd,
    output logic                mot_l_pwm,
    output logic                mot_r_pwm,
    output logic                mot_l_dir,
    output logic                mot_r_dir,
    output logic [PWM_BITS-1:0] duty_o,
    output logic [1:0]          state_o
);

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

`ifdef MOTOR_RAMP_EN
    localparam int RAMP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [RAMP_W-1:0]   RAMP_LAST  = RAMP_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_ENTRY = '0;
`else
    localparam logic [PWM_BITS-1:0] DUTY_ENTRY = DUTY_MAX;
`endif

    state_t              state, state_nxt;
    logic [1:0]          cmd_q;
    logic                fwd_q, fwd_d;
    logic                dir, dir_nxt;
    logic [PWM_BITS-1:0] duty, duty_nxt;
    logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
    logic                en_l, en_l_nxt, en_r, en_r_nxt;
`ifdef MOTOR_RAMP_EN
    logic [RAMP_W-1:0]   ramp_cnt, ramp_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STOP;
            cmd_q     <= CMD_STOP;
            fwd_q     <= 1'b1;
            fwd_d     <= 1'b1;
            dir       <= 1'b1;
            duty      <= '0;
            dwell_cnt <= '0;
            en_l      <= 1'b0;
            en_r      <= 1'b0;
`ifdef MOTOR_RAMP_EN
            ramp_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cmd_q     <= cmd;
            fwd_q     <= cmd_fwd;
            fwd_d     <= fwd_q;
            dir       <= dir_nxt;
            duty      <= duty_nxt;
            dwell_cnt <= dwell_nxt;
            en_l      <= en_l_nxt;
            en_r      <= en_r_nxt;
`ifdef MOTOR_RAMP_EN
            ramp_cnt  <= ramp_nxt;
`endif
        end
    end

    // fwd_d lags fwd_q by one clock so a fresh toggle during DWELL restarts the dead-time.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        duty_nxt  = duty;
        dwell_nxt = dwell_cnt;
        en_l_nxt  = en_l;
        en_r_nxt  = en_r;
`ifdef MOTOR_RAMP_EN
        ramp_nxt  = '0;
`endif
        case (state)
            ST_STOP: begin
                if (cmd_q != CMD_STOP) begin
                    state_nxt = ST_RUN;
                    dir_nxt   = fwd_q;
                    duty_nxt  = DUTY_ENTRY;
                    en_l_nxt  = cmd_q[0];
                    en_r_nxt  = cmd_q[1];
                end
            end
            ST_RUN: begin
                if (cmd_q == CMD_STOP) begin
                    state_nxt = ST_STOP;
                    duty_nxt  = '0;
                    en_l_nxt  = 1'b0;
                    en_r_nxt  = 1'b0;
                end else if (fwd_q != dir) begin
                    state_nxt = ST_DWELL;
                    duty_nxt  = '0;
                    dwell_nxt = '0;
                    en_l_nxt  = 1'b0;
                    en_r_nxt  = 1'b0;
                end else begin
                    en_l_nxt = cmd_q[0];
                    en_r_nxt = cmd_q[1];
`ifdef MOTOR_RAMP_EN
                    if (duty != DUTY_MAX) begin
                        if (ramp_cnt == RAMP_LAST) begin
                            duty_nxt = duty + PWM_BITS'(1);
                        end else begin
                            ramp_nxt = ramp_cnt + RAMP_W'(1);
                        end
                    end
`endif
                end
            end
            ST_DWELL: begin
                if (cmd_q == CMD_STOP) begin
                    state_nxt = ST_STOP;
                end else if (fwd_q != fwd_d) begin
                    dwell_nxt = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    state_nxt = ST_RUN;
                    dir_nxt   = fwd_q;
                    duty_nxt  = DUTY_ENTRY;
                    en_l_nxt  = cmd_q[0];
                    en_r_nxt  = cmd_q[1];
                end else begin
                    dwell_nxt = dwell_cnt + DWELL_W'(1);
                end
            end
            default: begin
                state_nxt = ST_STOP;
            end
        endcase
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_gen (
        .clk   (clk),
        .rst   (rst),
        .duty  (duty),
        .en_l  (en_l),
        .en_r  (en_r),
        .pwm_l (mot_l_pwm),
        .pwm_r (mot_r_pwm)
    );

    assign mot_l_dir = dir;
    assign mot_r_dir = dir;
    assign duty_o    = duty;
    assign state_o   = state;

endmodule
